// File: rtl/modmul_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett modular multiplier.
// Output-mode encoding lives here so every lane and client agrees on it.
package modmul_pkg;

  typedef enum logic {
    MODE_CENTERED  = 1'b0,
    MODE_CANONICAL = 1'b1
  } mode_e;

  function automatic int barrettK(input int w);
    return 2 * w;
  endfunction

  // M = floor(2^K / Q); the quotient estimate undershoots by at most one multiple of Q.
  function automatic longint barrettM(input int q, input int w);
    return (longint'(1) << barrettK(w)) / longint'(q);
  endfunction

  function automatic int halfQ(input int q);
    return (q - 1) / 2;
  endfunction

endpackage

// File: rtl/modmul_lane.sv
// One lane of the Barrett multiplier: product, quotient estimate, remainder registers,
// then the combinational correction that feeds the top-level output register.
module modmul_lane
  import modmul_pkg::*;
#(
  parameter int Q = 7681,
  parameter int W = 14
) (
  input  logic                clk,
  input  logic                en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                mode,
  output logic signed [W-1:0] c
);

  localparam int ZW = 2 * W;
  localparam int K  = barrettK(W);
  localparam int PW = ZW + K + 2;
  localparam int RW = W + 2;

  localparam logic signed [PW-1:0] M_P    = PW'(barrettM(Q, W));
  localparam logic signed [ZW-1:0] Q_Z    = ZW'(Q);
  localparam logic signed [RW-1:0] Q_R    = RW'(Q);
  localparam logic signed [RW-1:0] HALF_Q = RW'(halfQ(Q));

  logic signed [ZW-1:0] z_p1;
  logic signed [ZW-1:0] z_p2;
  logic signed [ZW-1:0] t_p2;
  logic signed [RW-1:0] r_p3;
  mode_e                mode_p1;
  mode_e                mode_p2;
  mode_e                mode_p3;

  // Folds r from [-Q, 2Q) into [0, Q-1], then optionally recentres around zero.
  function automatic logic signed [W-1:0] correctResidue(input logic signed [RW-1:0] r,
                                                         input mode_e md);
    logic signed [RW-1:0] u;
    u = r;
    if (r[RW-1]) u = r + Q_R;
    else if (r >= Q_R) u = r - Q_R;
    if (md == MODE_CENTERED && u > HALF_Q) u = u - Q_R;
    return W'(u);
  endfunction

  always_ff @(posedge clk) begin
    if (en) begin
      // S1: full signed product
      z_p1    <= ZW'(a) * ZW'(b);
      mode_p1 <= mode_e'(mode);
      // S2: quotient estimate
      z_p2    <= z_p1;
      t_p2    <= ZW'((PW'(z_p1) * M_P) >>> K);
      mode_p2 <= mode_p1;
      // S3: remainder, only the low W+2 bits matter
      r_p3    <= RW'(z_p2 - t_p2 * Q_Z);
      mode_p3 <= mode_p2;
    end
  end

  // S4: correction, registered by the parent
  assign c = correctResidue(r_p3, mode_p3);

endmodule

// File: rtl/modmul_pipe.sv
// Multi-lane pipelined signed modular multiplier with valid/ready handshake.
// The whole pipeline stalls together; a sideband tag rides along with each beat.
module modmul_pipe
  import modmul_pkg::*;
#(
  parameter int Q     = 7681,
  parameter int W     = 14,
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_c,
  output logic [TAG_W-1:0]     out_tag
);

  if (Q % 2 == 0 || Q <= 2 || Q >= (1 << (W - 1))) begin : g_badQ
    $error("modmul_pipe: Q must be odd with 2 < Q < 2^(W-1)");
  end

  logic               en;
  logic               accept;
  logic               vld_p1, vld_p2, vld_p3;
  logic [TAG_W-1:0]   tag_p1, tag_p2, tag_p3;
  logic [LANES*W-1:0] laneC;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign accept   = in_valid & en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modmul_lane #(
      .Q(Q),
      .W(W)
    ) u_lane (
      .clk (clk),
      .en  (en),
      .a   (in_a[i*W +: W]),
      .b   (in_b[i*W +: W]),
      .mode(in_mode),
      .c   (laneC[i*W +: W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      // S1..S3 valid pipe
      vld_p1    <= accept;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      // S4: output register
      out_valid <= vld_p3;
      out_c     <= laneC;
      out_tag   <= tag_p3;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_p1 <= in_tag;
      tag_p2 <= tag_p1;
      tag_p3 <= tag_p2;
    end
  end

endmodule

// File: tb/tb_modmul_pipe.sv
// Bench for modmul_pipe: directed corner values, randomized streaming with back-pressure
// against a plain modular-arithmetic model, async reset mid-stall, and a Q=12289 instance.
module tb_modmul_pipe;

  localparam int Q1 = 7681;
  localparam int W1 = 14;
  localparam int L1 = 4;
  localparam int Q2 = 12289;
  localparam int W2 = 15;

  typedef struct {
    logic [63:0] c;
    logic [7:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic              in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [L1*W1-1:0]  in_a, in_b, out_c;
  logic [7:0]        in_tag, out_tag;

  logic              valid2, inReady2, mode2, outValid2, outReady2;
  logic [W2-1:0]     a2, b2, outC2;
  logic [7:0]        tag2, outTag2;

  int nChecks = 0;
  int nFail   = 0;

  exp_t expQ[$];
  exp_t expQ2[$];
  int   aV[L1];
  int   bV[L1];
  int   popped = 0;
  int   sent   = 0;
  logic prevStall = 1'b0;
  logic [L1*W1-1:0] prevC;
  logic [7:0]       prevTag;

  always #5 clk = ~clk;

  modmul_pipe #(.Q(Q1), .W(W1), .LANES(L1), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag)
  );

  modmul_pipe #(.Q(Q2), .W(W2), .LANES(1), .TAG_W(8)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(valid2), .in_ready(inReady2),
    .in_a(a2), .in_b(b2), .in_mode(mode2), .in_tag(tag2),
    .out_valid(outValid2), .out_ready(outReady2),
    .out_c(outC2), .out_tag(outTag2)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer remainder, folded into the requested representation.
  function automatic longint refModel(input longint a, input longint b, input logic md,
                                      input longint q);
    longint m;
    m = (a * b) % q;
    if (m < 0) m += q;
    if (!md && m > (q - 1) / 2) m -= q;
    return m;
  endfunction

  function automatic logic [L1*W1-1:0] pack4(input int v0, input int v1, input int v2,
                                             input int v3);
    return {W1'(v3), W1'(v2), W1'(v1), W1'(v0)};
  endfunction

  function automatic logic [L1*W1-1:0] expVec(input logic md);
    logic [L1*W1-1:0] v;
    for (int i = 0; i < L1; i++) v[i*W1 +: W1] = W1'(refModel(aV[i], bV[i], md, Q1));
    return v;
  endfunction

  // One beat at a time with all lanes chosen by the caller; checks the 4-cycle latency.
  task automatic runDirected(input string name, input logic [L1*W1-1:0] va,
                             input logic [L1*W1-1:0] vb, input logic md,
                             input logic [7:0] tg, input logic [L1*W1-1:0] ec);
    int lat;
    in_a = va; in_b = vb; in_mode = md; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 checkVal({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checkVal({name, "_latency"}, 64'(lat), 64'd4);
    checkVal({name, "_c"}, 64'(out_c), 64'(ec));
    checkVal({name, "_tag"}, 64'(out_tag), 64'(tg));
  endtask

  // One randomized cycle on the main instance with scoreboard and stall checks.
  task automatic step(input logic vld, input logic rdy);
    exp_t e;
    @(negedge clk);
    in_valid  = vld;
    out_ready = rdy;
    in_mode   = 1'($urandom % 2);
    in_tag    = 8'($urandom);
    for (int i = 0; i < L1; i++) begin
      aV[i] = int'($urandom_range(Q1 - 1, 0)) - (Q1 - 1) / 2;
      bV[i] = int'($urandom_range(Q1 - 1, 0)) - (Q1 - 1) / 2;
      in_a[i*W1 +: W1] = W1'(aV[i]);
      in_b[i*W1 +: W1] = W1'(bV[i]);
    end
    #1;
    checkVal("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (prevStall) begin
      checkVal("hold_c", 64'(out_c), 64'(prevC));
      checkVal("hold_tag", 64'(out_tag), 64'(prevTag));
    end
    if (out_valid && out_ready) begin
      checkVal("beat_pending", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("beat_c", 64'(out_c), e.c);
        checkVal("beat_tag", 64'(out_tag), 64'(e.tag));
        popped++;
      end
    end
    if (in_valid && in_ready) begin
      e.c   = 64'(expVec(in_mode));
      e.tag = in_tag;
      expQ.push_back(e);
      sent++;
    end
    prevStall = out_valid && !out_ready;
    prevC     = out_c;
    prevTag   = out_tag;
  endtask

  task automatic pop2();
    exp_t e;
    if (outValid2 && outReady2) begin
      checkVal("q2_pending", 64'(expQ2.size() > 0), 64'd1);
      if (expQ2.size() > 0) begin
        e = expQ2.pop_front();
        checkVal("q2_c", 64'(outC2), e.c);
        checkVal("q2_tag", 64'(outTag2), 64'(e.tag));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int edgeSet[5];
    exp_t e;
    logic [W2-1:0] p2;
    edgeSet = '{6144, -6144, 1, -1, 0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0; in_tag = '0; in_a = '0; in_b = '0;
    valid2 = 1'b0; outReady2 = 1'b1; mode2 = 1'b0; tag2 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_out_c", 64'(out_c), 64'd0);
    checkVal("rst_out_tag", 64'(out_tag), 64'd0);
    checkVal("rst_in_ready", 64'(in_ready), 64'd1);

    // Test 1: first accept on the first edge after release
    @(negedge clk);
    rst = 1'b0;
    runDirected("t1_cent", pack4(3840, 3840, 3840, 3840), pack4(3840, 3840, 3840, 3840),
                1'b0, 8'h11, pack4(-1920, -1920, -1920, -1920));
    @(negedge clk);
    runDirected("t1_canon", pack4(3840, 3840, 3840, 3840), pack4(3840, 3840, 3840, 3840),
                1'b1, 8'h12, pack4(5761, 5761, 5761, 5761));

    // Test 2: mixed corner operands, one per lane
    @(negedge clk);
    runDirected("t2_canon", pack4(-3840, 1, 0, 3840), pack4(3840, -1, -3840, 3840),
                1'b1, 8'h21, pack4(1920, 7680, 0, 5761));
    @(negedge clk);
    runDirected("t2_cent", pack4(-3840, 1, 0, 3840), pack4(3840, -1, -3840, 3840),
                1'b0, 8'h22, pack4(1920, -1, 0, -1920));

    // Test 3: 64 back-to-back beats, all must be out 4 cycles after the last accept
    prevStall = 1'b0;
    p0 = popped;
    repeat (64) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    checkVal("t3_count", 64'(popped - p0), 64'd64);

    // Test 4: random valid and random back-pressure
    repeat (400) step(1'($urandom % 2), 1'($urandom % 2));
    repeat (10) step(1'b0, 1'b1);
    checkVal("t4_drained", 64'(expQ.size()), 64'd0);
    checkVal("t4_balance", 64'(popped), 64'(sent));

    // Test 5: async reset while stalled with beats in flight
    repeat (4) step(1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkVal("t5_stalled", 64'({out_valid, in_ready}), 64'b10);
    rst = 1'b1;
    #1;
    checkVal("t5_rst_valid", 64'(out_valid), 64'd0);
    checkVal("t5_rst_c", 64'(out_c), 64'd0);
    checkVal("t5_rst_in_ready", 64'(in_ready), 64'd1);
    expQ.delete();
    prevStall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runDirected("t5_post", pack4(1, -3840, 3840, 0), pack4(-1, 3840, 3840, 5),
                1'b1, 8'h55, pack4(7680, 1920, 5761, 0));
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkVal("t5_no_ghost", 64'(out_valid), 64'd0);

    // Test 6: Q=12289, W=15 single lane, exhaustive edge set
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          a2 = W2'(edgeSet[i]);
          b2 = W2'(edgeSet[j]);
          mode2 = 1'(md);
          tag2 = 8'(md * 25 + i * 5 + j);
          valid2 = 1'b1;
          #1;
          pop2();
          if (valid2 && inReady2) begin
            p2    = W2'(refModel(edgeSet[i], edgeSet[j], 1'(md), Q2));
            e.c   = 64'(p2);
            e.tag = tag2;
            expQ2.push_back(e);
          end
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      valid2 = 1'b0;
      #1;
      pop2();
    end
    checkVal("t6_drained", 64'(expQ2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
